mem_stage_dcache: RTL and testbench

Memory-stage data access block with a small direct-mapped, write-through, no-write-allocate data cache. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It takes the memory-stage address, store data and controls, and produces the load result `DMRd` consumed by the writeback register. It also produces a stall to the hazard unit while it talks to a multi-cycle backing memory.

---
 rtl/mem_stage_dcache_if.sv | 23 ++
 rtl/mem_stage_dcache.sv | 148 ++++++++++++++
 tb/tb_mem_stage_dcache.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_dcache_if.sv
// Backing-memory request/response bus between the M-stage data cache and memory.
// Single outstanding request; mem_ack is a one-cycle completion pulse.
interface mem_stage_dcache_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_dcache.sv
// M-stage data access: direct-mapped, write-through, no-write-allocate cache of
// one-word lines in front of a multi-cycle backing memory; stalls the pipe on misses/stores.
module mem_stage_dcache #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  output logic [DATA_WIDTH-1:0] DMRd,
  output logic                  StallM,
  mem_stage_dcache_if.master    mem
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(LINES);
  localparam int TAG_W     = DATA_WIDTH - 2 - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, WR_DONE} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  logic [1:0]            off;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [DATA_WIDTH-1:0] line_word;
  logic                  hit;

  assign off       = ALUResultM[1:0];
  assign idx       = ALUResultM[2 +: IDX_W];
  assign tag       = ALUResultM[DATA_WIDTH-1 -: TAG_W];
  assign line_word = data_q[idx];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);

  // Store lane enables and lane-replicated store data.
  logic [NUM_LANES-1:0]  st_strb;
  logic [DATA_WIDTH-1:0] st_wdata;

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << off;
        st_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << {off[1], 1'b0};
        st_wdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  logic [NUM_LANES-1:0][7:0] merged;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign merged[l] = st_strb[l] ? st_wdata[l*8 +: 8] : line_word[l*8 +: 8];
  end

  // Load extraction from the (hit) line word.
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_val;

  assign ld_byte = line_word[{off, 3'b000} +: 8];
  assign ld_half = line_word[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = line_word;
    case (funct3M)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b101:  ld_val = {16'b0, ld_half};
      default: ld_val = line_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    StallM  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemWriteM) begin
          state_d = WR_THRU;
          StallM  = 1'b1;
        end else if (MemReadM && !hit) begin
          state_d = RD_MISS;
          StallM  = 1'b1;
        end
      end
      RD_MISS: begin
        StallM = 1'b1;
        if (mem.mem_ack) state_d = IDLE;
      end
      WR_THRU: begin
        StallM = 1'b1;
        if (mem.mem_ack) state_d = WR_DONE;
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic req, we;
  assign req = (state_q == RD_MISS) || (state_q == WR_THRU);
  assign we  = (state_q == WR_THRU);

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = req ? {ALUResultM[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem.mem_wdata = we ? st_wdata : '0;
  assign mem.mem_wstrb = we ? st_strb : '0;

  assign DMRd = (MemReadM && !StallM && !MemWriteM) ? ld_val : '0;

  // Array writes are suppressed under reset so an abandoned refill cannot land.
  logic refill, wr_upd;
  assign refill = !rst && (state_q == RD_MISS) && mem.mem_ack;
  assign wr_upd = !rst && (state_q == WR_THRU) && mem.mem_ack && hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (refill) valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (refill) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem.mem_rdata;
    end else if (wr_upd) begin
      data_q[idx] <= merged;
    end
  end
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed bench for mem_stage_dcache: table of accesses with hand-computed
// stall counts, bus fields and load results, plus reset/stray-ack sequences.
module tb_mem_stage_dcache;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, DMRd;
  logic        MemReadM, MemWriteM, StallM;
  logic [2:0]  funct3M;

  mem_stage_dcache_if #(.DATA_WIDTH(32)) mif ();

  mem_stage_dcache #(.DATA_WIDTH(32), .LINES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .DMRd       (DMRd),
    .StallM     (StallM),
    .mem        (mif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          ack_after;
    logic [31:0] rdata;
    int          exp_stall;
    logic [31:0] exp_dmrd;
    int          exp_req;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  function automatic vec_t mk(string n, logic rd, logic wr, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd, int ack,
                              logic [31:0] rdat, int st, logic [31:0] dm, int rq,
                              logic we, logic [3:0] sb, logic [31:0] ea,
                              logic [31:0] ew);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd;
    v.ack_after = ack; v.rdata = rdat; v.exp_stall = st; v.exp_dmrd = dm;
    v.exp_req = rq; v.exp_we = we; v.exp_strb = sb; v.exp_addr = ea;
    v.exp_wdata = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_idle();
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b010;
    ALUResultM = '0; WriteDataM = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the first non-stalled cycle.
  task automatic run_vec(input vec_t v);
    int stall_n = 0, req_n = 0, bursts = 0;
    logic prev_req = 1'b0, done = 1'b0, idle_bad = 1'b0;
    logic [31:0] dm = '0, c_addr = '0, c_wdata = '0;
    logic [3:0]  c_strb = '0;
    logic        c_we = 1'b0;
    MemReadM = v.rd; MemWriteM = v.wr; funct3M = v.f3;
    ALUResultM = v.addr; WriteDataM = v.wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mif.mem_req) begin
        req_n++;
        if (!prev_req) bursts++;
        if (req_n == 1) begin
          c_addr = mif.mem_addr; c_we = mif.mem_we;
          c_strb = mif.mem_wstrb; c_wdata = mif.mem_wdata;
        end
        if (req_n == v.ack_after) begin
          mif.mem_ack = 1'b1; mif.mem_rdata = v.rdata;
        end
      end else if (mif.mem_addr != 0 || mif.mem_wstrb != 0 || mif.mem_wdata != 0) begin
        idle_bad = 1'b1;
      end
      prev_req = mif.mem_req;
      if (StallM) stall_n++;
      else begin dm = DMRd; done = 1'b1; end
      @(posedge clk); #1;
      mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    end
    chk({v.name, ".finished"}, 32'(done), 32'd1);
    chk({v.name, ".stall"}, stall_n, v.exp_stall);
    chk({v.name, ".dmrd"}, dm, v.exp_dmrd);
    chk({v.name, ".req_cycles"}, req_n, v.exp_req);
    chk({v.name, ".bus_zero_when_idle"}, 32'(idle_bad), 32'd0);
    if (v.exp_req > 0) begin
      chk({v.name, ".bursts"}, bursts, 1);
      chk({v.name, ".addr"}, c_addr, v.exp_addr);
      chk({v.name, ".we"}, 32'(c_we), 32'(v.exp_we));
      chk({v.name, ".wstrb"}, 32'(c_strb), 32'(v.exp_strb));
      if (v.exp_we) chk({v.name, ".wdata"}, c_wdata, v.exp_wdata);
    end
  endtask

  initial begin
    //              name             rd wr f3      addr        wd           ack rdata        st dmrd         rq we strb     eaddr       ewdata
    vecs.push_back(mk("lw_miss_40",   1, 0, 3'b010, 32'h40,  32'h0,         3, 32'hDEADBEEF, 4, 32'hDEADBEEF, 3, 0, 4'b0000, 32'h40,  32'h0));
    vecs.push_back(mk("lw_hit_40",    1, 0, 3'b010, 32'h40,  32'h0,         0, 32'h0,        0, 32'hDEADBEEF, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("sb_41",        0, 1, 3'b000, 32'h41,  32'h12,        1, 32'h0,        2, 32'h0,        1, 1, 4'b0010, 32'h40,  32'h12121212));
    vecs.push_back(mk("lw_40_merged", 1, 0, 3'b010, 32'h40,  32'h0,         0, 32'h0,        0, 32'hDEAD12EF, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("sw_44_noalloc",0, 1, 3'b010, 32'h44,  32'h80FF7F01,  2, 32'h0,        3, 32'h0,        2, 1, 4'b1111, 32'h44,  32'h80FF7F01));
    vecs.push_back(mk("lw_44_miss",   1, 0, 3'b010, 32'h44,  32'h0,         1, 32'h80FF7F01, 2, 32'h80FF7F01, 1, 0, 4'b0000, 32'h44,  32'h0));
    vecs.push_back(mk("lb_47",        1, 0, 3'b000, 32'h47,  32'h0,         0, 32'h0,        0, 32'hFFFFFF80, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("lbu_47",       1, 0, 3'b100, 32'h47,  32'h0,         0, 32'h0,        0, 32'h00000080, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("lh_47",        1, 0, 3'b001, 32'h47,  32'h0,         0, 32'h0,        0, 32'hFFFF80FF, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("lhu_46",       1, 0, 3'b101, 32'h46,  32'h0,         0, 32'h0,        0, 32'h000080FF, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("lh_46",        1, 0, 3'b001, 32'h46,  32'h0,         0, 32'h0,        0, 32'hFFFF80FF, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("lb_45",        1, 0, 3'b000, 32'h45,  32'h0,         0, 32'h0,        0, 32'h0000007F, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("lhu_44",       1, 0, 3'b101, 32'h44,  32'h0,         0, 32'h0,        0, 32'h00007F01, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("sw_100",       0, 1, 3'b010, 32'h100, 32'h11223344,  1, 32'h0,        2, 32'h0,        1, 1, 4'b1111, 32'h100, 32'h11223344));
    vecs.push_back(mk("lw_100_miss",  1, 0, 3'b010, 32'h100, 32'h0,         2, 32'h11223344, 3, 32'h11223344, 2, 0, 4'b0000, 32'h100, 32'h0));
    vecs.push_back(mk("sh_102",       0, 1, 3'b001, 32'h102, 32'h0000ABCD,  1, 32'h0,        2, 32'h0,        1, 1, 4'b1100, 32'h100, 32'hABCDABCD));
    vecs.push_back(mk("lw_100_sh",    1, 0, 3'b010, 32'h100, 32'h0,         0, 32'h0,        0, 32'hABCD3344, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("rdwr_100",     1, 1, 3'b010, 32'h100, 32'h55667788,  1, 32'h0,        2, 32'h0,        1, 1, 4'b1111, 32'h100, 32'h55667788));
    vecs.push_back(mk("lw_100_rdwr",  1, 0, 3'b010, 32'h100, 32'h0,         0, 32'h0,        0, 32'h55667788, 0, 0, 4'b0000, 32'h0,   32'h0));
    vecs.push_back(mk("lw_140_confl", 1, 0, 3'b010, 32'h140, 32'h0,         1, 32'hCAFEF00D, 2, 32'hCAFEF00D, 1, 0, 4'b0000, 32'h140, 32'h0));
    vecs.push_back(mk("lw_100_evict", 1, 0, 3'b010, 32'h100, 32'h0,         1, 32'h55667788, 2, 32'h55667788, 1, 0, 4'b0000, 32'h100, 32'h0));
    vecs.push_back(mk("sb_143_miss",  0, 1, 3'b000, 32'h143, 32'hFFFFFF5A,  1, 32'h0,        2, 32'h0,        1, 1, 4'b1000, 32'h140, 32'h5A5A5A5A));
    vecs.push_back(mk("lw_100_kept",  1, 0, 3'b010, 32'h100, 32'h0,         0, 32'h0,        0, 32'h55667788, 0, 0, 4'b0000, 32'h0,   32'h0));

    rst = 1'b1;
    set_idle();
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    chk("reset.stall", 32'(StallM), 32'd0);
    chk("reset.req", 32'(mif.mem_req), 32'd0);
    chk("reset.dmrd", DMRd, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Ack while idle must not touch the cache.
    set_idle();
    @(negedge clk);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    run_vec(mk("stray_ack_idle", 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0, 0, 32'h55667788, 0, 0, 4'b0000, 32'h0, 32'h0));

    // Reset while a refill is outstanding, then a late ack.
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h40;
    @(negedge clk);
    chk("rstmid.idle_stall", 32'(StallM), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid.req_before", 32'(mif.mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    chk("rstmid.req_after", 32'(mif.mem_req), 32'd0);
    chk("rstmid.stall_after", 32'(StallM), 32'd0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    @(negedge clk);
    chk("rstmid.late_ack_ignored", 32'(mif.mem_req), 32'd0);
    @(posedge clk); #1;
    run_vec(mk("rst_lw_100_miss", 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'h12345678, 2, 32'h12345678, 1, 0, 4'b0000, 32'h100, 32'h0));
    run_vec(mk("rst_lw_44_miss",  1, 0, 3'b010, 32'h44,  32'h0, 1, 32'h44444444, 2, 32'h44444444, 1, 0, 4'b0000, 32'h44,  32'h0));
    run_vec(mk("rst_lw_40_miss",  1, 0, 3'b010, 32'h40,  32'h0, 2, 32'hDEADBEEF, 3, 32'hDEADBEEF, 2, 0, 4'b0000, 32'h40,  32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
